// File: rtl/inst_refill_pkg.sv
// Shared definitions for the instruction-cache refill path: FSM encoding,
// refill word geometry and the byte-wide RAM port field widths that the
// memory arbiter and load/store unit also use.
package inst_refill_pkg;

    // Default address width of miss, RAM and cache-update addresses.
    localparam int DEF_ADDR_W = 32;

    // Bytes fetched per refilled instruction word.
    localparam int REFILL_WORD_BYTES = 4;

    // RAM port field widths shared by every arbiter client.
    localparam int RAM_DATA_W = 8;
    localparam int RAM_REQ_W  = 1;
    localparam int RAM_GNT_W  = 1;

    // Refill sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } refill_state_t;

    // Counter width able to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/inst_refill_unit.sv
// Miss-side filler for the direct-mapped instruction cache. Reads WORD_BYTES
// consecutive bytes from the byte-wide RAM port, assembles them little-endian
// and presents the word on the cache update port with a single-cycle strobe.
module inst_refill_unit
    import inst_refill_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORD_BYTES = REFILL_WORD_BYTES
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    miss_valid,
    input  logic [ADDR_W-1:0]       miss_addr,
    input  logic                    flush,
    output logic [RAM_REQ_W-1:0]    mem_req,
    input  logic [RAM_GNT_W-1:0]    mem_grant,
    output logic [ADDR_W-1:0]       mem_a,
    input  logic [RAM_DATA_W-1:0]   mem_din,
    output logic                    upd_valid,
    output logic [ADDR_W-1:0]       upd_addr,
    output logic [8*WORD_BYTES-1:0] upd_data,
    output logic                    busy
);

    localparam int CNT_W = cnt_width(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    refill_state_t           state;
    refill_state_t           state_nxt;
    logic [ADDR_W-1:0]       base;
    logic [CNT_W-1:0]        issue_cnt;
    logic [CNT_W-1:0]        recv_cnt;
    logic                    pend;
    logic [8*WORD_BYTES-1:0] word;
    logic [ADDR_W-1:0]       hold_addr;
    logic [8*WORD_BYTES-1:0] hold_data;

    logic accept;
    logic issue;
    logic flush_act;
    logic all_captured;

    // A flush only takes effect while the pipeline is not paused.
    assign flush_act = rdy_in && flush;

    // Every byte is in once the capture now in progress (if any) lands.
    assign all_captured = (recv_cnt == CNT_FULL) || (pend && (recv_cnt == CNT_LAST));

    // An issue is a request the arbiter grants in the same cycle.
    assign issue = mem_req[0] && mem_grant[0];

    // RAM byte address: start of the word plus bytes already issued, wrapping at ADDR_W.
    assign mem_a = base + ADDR_W'(issue_cnt);

    assign busy = (state != ST_IDLE);

    // The update port shows the live word during the strobe and holds the last delivered word otherwise.
    assign upd_addr = upd_valid ? base : hold_addr;
    assign upd_data = upd_valid ? word : hold_data;

    // State register.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and combinational handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
        state_nxt = state;
        accept    = 1'b0;
        mem_req   = '0;
        upd_valid = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (rdy_in && !flush && miss_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req[0] = rdy_in && (issue_cnt < CNT_FULL);
                if (flush_act) begin
                    state_nxt = ST_IDLE;
                end else if (rdy_in && all_captured) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                // Strobe only in the cycle that actually leaves DONE, so it is one pulse even under pause.
                upd_valid = rdy_in && !flush;
                if (rdy_in) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Refill datapath: latch the start address, count issues, capture returning bytes.
    always_ff @(posedge clk_in) begin
        // NOTE: the assembly word is an ordinary register (not a RAM), so it is cleared with the rest on reset.
        if (rst_in) begin
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
            word      <= '0;
        end else if (accept) begin
            base      <= miss_addr;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            pend      <= 1'b0;
        end else if (state == ST_FETCH) begin
            // The RAM returns data one cycle after the address; that capture ignores rdy_in and grant.
            pend <= issue && !flush_act;
            if (issue) begin
                issue_cnt <= issue_cnt + CNT_ONE;
            end
            if (pend && !flush_act) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (recv_cnt == CNT_W'(b)) begin
                        word[8*b +: 8] <= mem_din;
                    end
                end
                recv_cnt <= recv_cnt + CNT_ONE;
            end
        end
    end

    // Remember the last word delivered to the cache so the update port holds it afterwards.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_addr <= '0;
            hold_data <= '0;
        end else if (upd_valid) begin
            hold_addr <= base;
            hold_data <= word;
        end
    end

endmodule

// File: tb/tb_inst_refill_unit.sv
// Self-checking bench for inst_refill_unit: a byte-addressed RAM model answers
// granted reads, a scoreboard holds the expected RAM addresses and cache
// updates, and a negedge monitor compares them as the DUT presents them.
module tb_inst_refill_unit;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        flush;
    logic [0:0]  mem_req;
    logic [0:0]  mem_grant;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
    logic        upd_valid;
    logic [31:0] upd_addr;
    logic [31:0] upd_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 0;

    logic [31:0] addr_q[$];
    logic [63:0] upd_q[$];
    logic [7:0]  ram_mem[logic [31:0]];
    logic [7:0]  din_stage = 8'h00;

    inst_refill_unit dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_grant  (mem_grant),
        .mem_a      (mem_a),
        .mem_din    (mem_din),
        .upd_valid  (upd_valid),
        .upd_addr   (upd_addr),
        .upd_data   (upd_data),
        .busy       (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sparse RAM: explicitly written bytes, otherwise a fixed function of the address.
    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    // RAM data appears one cycle after a granted address; junk otherwise.
    always @(posedge clk_in) begin
        #1;
        mem_din = din_stage;
    end

    // Monitor: checks every granted RAM address and every cache update against the scoreboard.
    always @(negedge clk_in) begin
        logic [31:0] exp_a;
        logic [63:0] exp_u;
        din_stage = 8'($urandom);
        if (mon_en) begin
            if (mem_req[0] && mem_grant[0]) begin
                din_stage = ram_rd(mem_a);
                if (addr_q.size() == 0) begin
                    check("unexpected_mem_issue", 64'(mem_a), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_a = addr_q.pop_front();
                    check("mem_a", 64'(mem_a), 64'(exp_a));
                end
            end
            if (upd_valid) begin
                if (upd_q.size() == 0) begin
                    check("unexpected_upd_valid", 64'(upd_valid), 64'd0);
                end else begin
                    exp_u = upd_q.pop_front();
                    check("upd_addr", 64'(upd_addr), 64'(exp_u[63:32]));
                    check("upd_data", 64'(upd_data), 64'(exp_u[31:0]));
                end
            end
        end
    end

    // Push the expected RAM addresses and little-endian word for a refill of a, then raise the miss.
    task automatic start_miss(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(a + 32'(i));
            w[8*i +: 8] = ram_rd(a + 32'(i));
        end
        upd_q.push_back({a, w});
        miss_addr  = a;
        miss_valid = 1'b1;
    endtask

    // One full refill with per-cycle grant/ready-low masks; exp_lat < 0 skips the latency check.
    task automatic run_refill(input logic [31:0] a, input logic [15:0] gmask,
                              input logic [15:0] rmask, input int exp_lat);
        int  lat;
        bit  g_low;
        bit  r_low;
        lat = -1;
        for (int c = 0; c < 120 && lat < 0; c++) begin
            @(posedge clk_in);
            #1;
            if (c == 0) start_miss(a);
            g_low     = (c < 16) ? gmask[c] : 1'b0;
            r_low     = (c < 16) ? rmask[c] : 1'b0;
            mem_grant = !g_low;
            rdy_in    = !r_low;
            @(negedge clk_in);
            if (r_low) check("mem_req_paused", 64'(mem_req), 64'd0);
            if (upd_valid) lat = c;
        end
        @(posedge clk_in);
        #1;
        miss_valid = 1'b0;
        mem_grant  = 1'b1;
        rdy_in     = 1'b1;
        @(negedge clk_in);
        check("upd_single_pulse", 64'(upd_valid), 64'd0);
        if (exp_lat >= 0) check("upd_latency", 64'(lat), 64'(exp_lat));
        else              check("refill_completed", 64'(lat >= 0), 64'd1);
    endtask

    // Start a refill with full grant and flush it in cycle fc (counted from the accept cycle).
    task automatic flush_refill(input logic [31:0] a, input int fc);
        @(posedge clk_in);
        #1;
        start_miss(a);
        mem_grant = 1'b1;
        rdy_in    = 1'b1;
        for (int c = 1; c <= fc; c++) begin
            @(posedge clk_in);
            #1;
        end
        flush      = 1'b1;
        miss_valid = 1'b0;
        void'(upd_q.pop_back());
        @(negedge clk_in);
        check("upd_valid_flushed", 64'(upd_valid), 64'd0);
        @(posedge clk_in);
        #1;
        flush = 1'b0;
        addr_q.delete();
        @(negedge clk_in);
        check("busy_after_flush", 64'(busy), 64'd0);
        check("mem_req_after_flush", 64'(mem_req), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   64'(mem_req),   64'd0);
        check({tag, "_mem_a"},     64'(mem_a),     64'd0);
        check({tag, "_upd_valid"}, 64'(upd_valid), 64'd0);
        check({tag, "_upd_addr"},  64'(upd_addr),  64'd0);
        check({tag, "_upd_data"},  64'(upd_data),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    // Directed scenarios followed by randomized refills under random grant and pause patterns.
    initial begin
        logic [31:0] ra;
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        miss_valid = 1'b0;
        miss_addr  = '0;
        flush      = 1'b0;
        mem_grant  = 1'b1;
        mem_din    = '0;

        ram_mem[32'h100] = 8'h11;
        ram_mem[32'h101] = 8'h22;
        ram_mem[32'h102] = 8'h33;
        ram_mem[32'h103] = 8'h44;
        ram_mem[32'h104] = 8'h55;
        ram_mem[32'h105] = 8'h66;

        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mon_en = 1'b1;
        @(negedge clk_in);
        check_reset_outputs("reset");

        // Basic refill, full grant: update in cycle 6.
        run_refill(32'h100, 16'h0000, 16'h0000, 6);
        // Halfword-aligned start crossing into the next word.
        run_refill(32'h102, 16'h0000, 16'h0000, 6);
        // Grant low in cycles 2-4: three cycles later.
        run_refill(32'h100, 16'h001C, 16'h0000, 9);
        // Pause in cycles 2-3 mid-fetch: two cycles later.
        run_refill(32'h102, 16'h0000, 16'h000C, 8);

        // Flush mid-fetch and in the update cycle, each followed by a clean refill.
        flush_refill(32'h100, 3);
        run_refill(32'h104, 16'h0000, 16'h0000, 6);
        flush_refill(32'h102, 6);
        run_refill(32'h100, 16'h0000, 16'h0000, 6);

        // Flush wins over a simultaneous miss in IDLE.
        @(posedge clk_in);
        #1;
        miss_addr  = 32'h200;
        miss_valid = 1'b1;
        flush      = 1'b1;
        @(posedge clk_in);
        #1;
        miss_valid = 1'b0;
        flush      = 1'b0;
        @(negedge clk_in);
        check("flush_beats_miss_busy", 64'(busy), 64'd0);

        // Reset in the middle of a fetch clears every output, including the held update word.
        @(posedge clk_in);
        #1;
        start_miss(32'h300);
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        rst_in     = 1'b1;
        miss_valid = 1'b0;
        void'(upd_q.pop_back());
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        addr_q.delete();
        @(negedge clk_in);
        check_reset_outputs("midreset");

        // Address wrap at the top of the address space.
        run_refill(32'hFFFF_FFFE, 16'h0000, 16'h0000, 6);

        // Randomized refills with random grant gaps and pauses.
        for (int n = 0; n < 24; n++) begin
            ra = $urandom & 32'hFFFF_FFFE;
            run_refill(ra, 16'($urandom & $urandom),
                       16'($urandom & $urandom & $urandom), -1);
        end

        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        check("upd_queue_drained",  64'(upd_q.size()),  64'd0);
        check("addr_queue_drained", 64'(addr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
